// File: rtl/core_run_ctrl.sv
// Program store and run sequencer for the 4-bit accumulator core.
// Loads an image over a byte stream, then gates core reset and clock enable.
module core_run_ctrl #(
    parameter int PC_LEN    = 7,
    parameter int INSTR_LEN = 8,
    parameter int CNT_LEN   = 16
) (
    input  logic                 CLK,
    input  logic                 RST,
    input  logic                 LOAD_VALID,
    output logic                 LOAD_READY,
    input  logic [INSTR_LEN-1:0] LOAD_DATA,
    input  logic                 LOAD_LAST,
    input  logic                 CMD_VALID,
    input  logic [1:0]           CMD,
    input  logic                 BREAK_EN,
    input  logic [PC_LEN-1:0]    BREAK_ADDR,
    input  logic [PC_LEN-1:0]    PC,
    output logic [INSTR_LEN-1:0] INSTR,
    output logic                 CORE_RSTN,
    output logic                 CORE_CE,
    output logic [2:0]           STATE,
    output logic                 HALTED,
    output logic [CNT_LEN-1:0]   INSTR_CNT
);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_LOAD  = 3'd1,
        S_READY = 3'd2,
        S_RUN   = 3'd3,
        S_STEP  = 3'd4,
        S_HALT  = 3'd5
    } state_e;

    localparam int DEPTH = 2 ** PC_LEN;
    localparam logic [1:0] C_RUN    = 2'b00;
    localparam logic [1:0] C_STOP   = 2'b01;
    localparam logic [1:0] C_STEP   = 2'b10;
    localparam logic [1:0] C_RELOAD = 2'b11;

    logic [INSTR_LEN-1:0] mem_q [DEPTH];
    state_e               state_q;
    logic [PC_LEN-1:0]    addr_q;
    logic [PC_LEN:0]      len_q;
    logic                 skip_q;
    logic [CNT_LEN-1:0]   cnt_q;
    logic [CNT_LEN-1:0]   cnt_d;

    logic bp_hit;
    logic beat;
    logic ce;
    logic cmd_run;
    logic cmd_stop;
    logic cmd_step;
    logic cmd_reload;

    assign bp_hit     = BREAK_EN && (PC == BREAK_ADDR);
    assign beat       = LOAD_VALID && (state_q == S_LOAD);
    assign cmd_run    = CMD_VALID && (CMD == C_RUN);
    assign cmd_stop   = CMD_VALID && (CMD == C_STOP);
    assign cmd_step   = CMD_VALID && (CMD == C_STEP);
    assign cmd_reload = CMD_VALID && (CMD == C_RELOAD);

    // Core clock enable; a breakpoint blocks execution unless we are leaving it
    always_comb begin
        ce = 1'b0;
        unique case (state_q)
            S_STEP:  ce = 1'b1;
            S_RUN:   ce = !(bp_hit && !skip_q);
            default: ce = 1'b0;
        endcase
    end

    // Retired-instruction count, saturating at all-ones
    always_comb begin
        cnt_d = cnt_q;
        if (ce && !(&cnt_q)) begin
            cnt_d = cnt_q + CNT_LEN'(1);
        end
    end

    // Instruction store write port; contents survive reset
    always_ff @(posedge CLK) begin
        if (!RST && beat) begin
            mem_q[addr_q] <= LOAD_DATA;
        end
    end

    // Run-control state machine
    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q <= S_IDLE;
            addr_q  <= '0;
            len_q   <= '0;
            skip_q  <= 1'b0;
            cnt_q   <= '0;
        end else begin
            cnt_q <= cnt_d;
            unique case (state_q)
                S_IDLE: begin
                    if (cmd_reload) begin
                        state_q <= S_LOAD;
                        addr_q  <= '0;
                        len_q   <= '0;
                        cnt_q   <= '0;
                    end
                end
                S_LOAD: begin
                    if (beat) begin
                        addr_q <= addr_q + PC_LEN'(1);
                        if (LOAD_LAST || (&addr_q)) begin
                            state_q <= S_READY;
                            len_q   <= {1'b0, addr_q} + (PC_LEN + 1)'(1);
                        end
                    end
                end
                S_READY: begin
                    if (cmd_run) begin
                        state_q <= S_RUN;
                        skip_q  <= 1'b0;
                    end else if (cmd_step) begin
                        state_q <= S_STEP;
                    end else if (cmd_reload) begin
                        state_q <= S_LOAD;
                        addr_q  <= '0;
                        len_q   <= '0;
                        cnt_q   <= '0;
                    end
                end
                S_RUN: begin
                    skip_q <= 1'b0;
                    if (cmd_stop || (bp_hit && !skip_q)) begin
                        state_q <= S_HALT;
                    end
                end
                S_STEP: begin
                    state_q <= S_HALT;
                end
                S_HALT: begin
                    if (cmd_run) begin
                        state_q <= S_RUN;
                        skip_q  <= 1'b1;
                    end else if (cmd_step) begin
                        state_q <= S_STEP;
                    end else if (cmd_reload) begin
                        state_q <= S_LOAD;
                        addr_q  <= '0;
                        len_q   <= '0;
                        cnt_q   <= '0;
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign INSTR      = ({1'b0, PC} < len_q) ? mem_q[PC] : '0;
    assign CORE_CE    = ce;
    assign CORE_RSTN  = (state_q == S_RUN) || (state_q == S_STEP) ||
                        (state_q == S_HALT);
    assign LOAD_READY = (state_q == S_LOAD);
    assign HALTED     = (state_q == S_HALT);
    assign STATE      = state_q;
    assign INSTR_CNT  = cnt_q;

endmodule

// File: doc/core_run_ctrl.md
Name: core_run_ctrl

Overview:
- Program-memory and run controller for the 4-bit accumulator core (8-bit instructions, 7-bit PC).
- Accepts a program image over a valid/ready byte stream into a 128x8 instruction store and drives the core's INSTR from the core's PC.
- Sequences the core through hold-in-reset, run, single-step, breakpoint and halt via CORE_RSTN and a clock-enable (CORE_CE) consumed at integration.

Parameters:
PC_LEN, 7, core PC width; store depth is 2**PC_LEN
INSTR_LEN, 8, instruction width
CNT_LEN, 16, retired-instruction counter width

Ports:
CLK  in  1  clock, all logic on posedge
RST  in  1  synchronous reset, active-high
LOAD_VALID  in  1  program byte valid
LOAD_READY  out  1  controller accepts program byte
LOAD_DATA  in  INSTR_LEN  program byte
LOAD_LAST  in  1  final byte of image, qualified by VALID&&READY
CMD_VALID  in  1  command strobe, one-cycle
CMD  in  2  00 RUN, 01 STOP, 10 STEP, 11 RELOAD
BREAK_EN  in  1  breakpoint enable
BREAK_ADDR  in  PC_LEN  breakpoint PC
PC  in  PC_LEN  core program counter
INSTR  out  INSTR_LEN  instruction to core
CORE_RSTN  out  1  core reset, active-low
CORE_CE  out  1  core clock enable
STATE  out  3  IDLE=0 LOAD=1 READY=2 RUN=3 STEP=4 HALT=5
HALTED  out  1  STATE==HALT
INSTR_CNT  out  CNT_LEN  retired instructions

Behaviour:
- Reset (RST=1 at posedge, any state incl. mid-load/run): STATE=IDLE, LEN=0, addr=0, INSTR_CNT=0, skip=0. Store contents not cleared.
- Outputs, by state: CORE_RSTN=0 in IDLE/LOAD/READY, 1 in RUN/STEP/HALT. LOAD_READY=1 only in LOAD.
- INSTR (combinational): store[PC] when PC<LEN, else 8'h00.
- CORE_CE (combinational):
  - STEP: 1.
  - RUN: 1 unless bp_hit && !skip.
  - All other states: 0.
  - bp_hit = BREAK_EN && PC==BREAK_ADDR.
- Commands are sampled at posedge when CMD_VALID=1 and take effect the next cycle. CORE_CE in the sampling cycle is unaffected. Commands not listed for a state are ignored.
- IDLE: RELOAD -> LOAD.
- LOAD:
  - Each VALID&&READY beat writes LOAD_DATA to store[addr], then addr++.
  - Beat with LOAD_LAST=1, or beat at addr=127, -> READY with LEN=addr+1 (range 1..128).
  - All commands ignored.
  - On entry: addr=0, INSTR_CNT=0, LEN=0.
- READY: RUN -> RUN (skip=0); STEP -> STEP; RELOAD -> LOAD.
- RUN:
  - STOP -> HALT.
  - bp_hit && !skip -> HALT. The breakpoint instruction is not executed (CE=0 that cycle).
  - skip clears after the first RUN cycle.
  - STOP and bp_hit in the same cycle -> HALT, CE=0.
- STEP: CE=1 for exactly one cycle, then -> HALT. Breakpoint is not checked. Commands ignored.
- HALT: RUN -> RUN with skip=1, so the core can leave a breakpoint PC; STEP -> STEP; RELOAD -> LOAD. Core state is preserved (CORE_RSTN=1).
- INSTR_CNT: +1 every cycle CORE_CE=1, saturates at all-ones, cleared on RST and on LOAD entry.
- LEN and the store are unchanged outside LOAD. A partial reload of N bytes makes locations >=N read 8'h00.

Test Plan:
- Reset, RELOAD, stream 3 bytes 0x41,0x12,0x70 (LAST on 3rd) -> STATE 1->2, LEN=3, LOAD_READY low after the LAST beat; CORE_RSTN=0 throughout. With PC=1 -> INSTR=0x12; PC=5 -> INSTR=0x00.
- Stream 128 bytes without LAST -> READY after the 128th beat, LEN=128. Further LOAD_VALID is not accepted (LOAD_READY=0).
- RUN from READY, BREAK_EN=1, BREAK_ADDR=4, PC counts 0..4 -> CE high for PC 0..3, low at PC=4. STATE=HALT, HALTED=1, INSTR_CNT=4.
- From that HALT, issue RUN while PC=4 -> CE=1 in the first RUN cycle (skip). Execution continues; INSTR_CNT increments past 4.
- From HALT, issue STEP -> exactly one CE pulse, STATE 5->4->5, INSTR_CNT +1. A second STEP during STEP is ignored.
- Assert RST in RUN mid-program -> next cycle STATE=IDLE, CORE_RSTN=0, CE=0, INSTR_CNT=0, LEN=0 (INSTR=0x00 for any PC).
